// File: rtl/theremin_pkg.sv
// rtl/theremin_pkg.sv - shared types and defaults for the theremin pitch path
package theremin_pkg;

   typedef enum logic [1:0] {GL_SETTLED, GL_UP, GL_DN} glide_state_t;

   localparam int GLIDE_TICK_DIV_DEF = 500;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running prescaler, one-cycle tick every DIV clocks
module tick_gen #(
   parameter int DIV = 500
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] count;

   assign tick = (count == CW'(DIV - 1));

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (tick)
         count <= '0;
      else
         count <= count + 1'b1;
   end

endmodule

// File: rtl/freq_glide.sv
// rtl/freq_glide.sv - portamento slew limiter between pitch word and tone_gen
module freq_glide
   import theremin_pkg::*;
#(
   parameter int F_BITS   = 14,
   parameter int FRAC_B   = 8,
   parameter int TICK_DIV = GLIDE_TICK_DIV_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [F_BITS-1:0] in_freq,
   input  logic              in_valid,
   input  logic [7:0]        rate,
   output logic [F_BITS-1:0] out_freq,
   output logic              out_valid,
   output logic              settled
);

   localparam int W = F_BITS + FRAC_B;

   logic              tick;
   logic [F_BITS-1:0] target;
   logic [W-1:0]      acc, acc_next, tgt_x;
   logic [8:0]        step;
   logic [W:0]        step_ext, sum, diff;
   glide_state_t      state, state_next;

   tick_gen #(.DIV(TICK_DIV)) tick_inst (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // Extra top bit on add/subtract lets the clamp see overflow and borrow.
   assign tgt_x    = {target, {FRAC_B{1'b0}}};
   assign step     = 9'd256 - {1'b0, rate};
   assign step_ext = {{(W - 8){1'b0}}, step};
   assign sum      = {1'b0, acc} + step_ext;
   assign diff     = {1'b0, acc} - step_ext;

   always_comb begin
      acc_next   = acc;
      state_next = state;
      if (tick) begin
         if (rate == 8'd0) begin
            acc_next   = tgt_x;
            state_next = GL_SETTLED;
         end else begin
            unique case (state)
               GL_SETTLED: begin
                  if (acc < tgt_x)
                     state_next = GL_UP;
                  else if (acc > tgt_x)
                     state_next = GL_DN;
               end
               GL_UP: begin
                  if (acc > tgt_x)
                     state_next = GL_DN;
                  else if (sum >= {1'b0, tgt_x}) begin
                     acc_next   = tgt_x;
                     state_next = GL_SETTLED;
                  end else
                     acc_next = sum[W-1:0];
               end
               GL_DN: begin
                  if (acc < tgt_x)
                     state_next = GL_UP;
                  else if (diff[W] || (diff[W-1:0] <= tgt_x)) begin
                     acc_next   = tgt_x;
                     state_next = GL_SETTLED;
                  end else
                     acc_next = diff[W-1:0];
               end
               default: state_next = GL_SETTLED;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         target    <= '0;
         acc       <= '0;
         state     <= GL_SETTLED;
         out_freq  <= '0;
         out_valid <= 1'b0;
         settled   <= 1'b1;
      end else begin
         if (in_valid)
            target <= in_freq;
         acc       <= acc_next;
         state     <= state_next;
         out_valid <= tick;
         if (tick) begin
            out_freq <= acc_next[W-1:FRAC_B];
            settled  <= (state_next == GL_SETTLED);
         end
      end
   end

endmodule

// File: tb/tb_freq_glide.sv
// tb/tb_freq_glide.sv - directed self-checking bench for freq_glide
module tb_freq_glide;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [13:0] in_freq = '0;
   logic        in_valid = 1'b0;
   logic [7:0]  rate = '0;
   logic [13:0] out_freq;
   logic        out_valid;
   logic        settled;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   freq_glide #(.F_BITS(14), .FRAC_B(8), .TICK_DIV(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_freq   (in_freq),
      .in_valid  (in_valid),
      .rate      (rate),
      .out_freq  (out_freq),
      .out_valid (out_valid),
      .settled   (settled)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic wait_upd();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 8);
      if (!out_valid) chk("upd_timeout", 0, 1);
   endtask

   // Reset, then strobe a first target on the release cycle.
   task automatic rst_go(input logic [13:0] f, input logic [7:0] r);
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      reset    = 1'b0;
      rate     = r;
      in_freq  = f;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic strobe(input logic [13:0] f);
      in_freq  = f;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      int found;
      int k;
      int ea;

      // T1: reset held with in_valid asserted
      in_valid = 1'b1;
      in_freq  = 14'd123;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t1_freq", 32'(out_freq), 0);
         chk("t1_valid", 32'(out_valid), 0);
         chk("t1_settled", 32'(settled), 1);
      end

      // T2: bypass
      rst_go(14'd1000, 8'd0);
      found = 0;
      for (int i = 0; i < 6; i++) begin
         if (out_freq == 14'd1000) found = 1;
         if (found == 0) @(negedge clk);
      end
      if (out_freq == 14'd1000) found = 1;
      chk("t2_reach", 32'(found), 1);
      chk("t2_settled", 32'(settled), 1);

      // T3: slow rise at half an LSB per tick
      rst_go(14'd10, 8'd128);
      for (int i = 0; i <= 20; i++) begin
         wait_upd();
         chk("t3_freq", 32'(out_freq), 32'(i / 2));
         chk("t3_settled", 32'(settled), (i == 20) ? 1 : 0);
      end
      wait_upd();
      chk("t3_hold", 32'(out_freq), 10);
      chk("t3_hold_settled", 32'(settled), 1);

      // T4: fall with clamp
      rst_go(14'd5, 8'd0);
      wait_upd();
      chk("t4_start", 32'(out_freq), 5);
      rate = 8'd1;
      strobe(14'd4);
      wait_upd();
      chk("t4_entry", 32'(out_freq), 5);
      chk("t4_entry_settled", 32'(settled), 0);
      wait_upd();
      chk("t4_move", 32'(out_freq), 4);
      chk("t4_move_settled", 32'(settled), 0);
      wait_upd();
      chk("t4_clamp", 32'(out_freq), 4);
      chk("t4_clamp_settled", 32'(settled), 1);

      // T5: reversal mid-glide, step 56
      rst_go(14'd100, 8'd200);
      k = 0;
      do begin
         wait_upd();
         k++;
      end while (out_freq < 14'd50 && k < 400);
      chk("t5_up_ticks", 32'(k), 230);
      chk("t5_up_freq", 32'(out_freq), 50);
      strobe(14'd20);
      wait_upd();
      chk("t5_reverse_hold", 32'(out_freq), 50);
      ea = 229 * 56;
      for (int i = 1; i <= 138; i++) begin
         wait_upd();
         ea = (ea - 56 < 20 * 256) ? 20 * 256 : ea - 56;
         chk("t5_dn_freq", 32'(out_freq), 32'(ea / 256));
         chk("t5_dn_settled", 32'(settled), (i == 138) ? 1 : 0);
      end

      // T6a: strobe on the tick cycle sees the old target first
      rst_go(14'd300, 8'd0);
      wait_upd();
      chk("t6_first", 32'(out_freq), 300);
      repeat (3) @(negedge clk);
      strobe(14'd700);
      chk("t6_collide_valid", 32'(out_valid), 1);
      chk("t6_collide_old", 32'(out_freq), 300);
      wait_upd();
      chk("t6_new", 32'(out_freq), 700);

      // T6b: reset mid-glide
      rate = 8'd255;
      strobe(14'd1000);
      wait_upd();
      wait_upd();
      chk("t6_gliding", 32'(settled), 0);
      chk("t6_pre_reset", 32'(out_freq), 700);
      reset = 1'b1;
      @(negedge clk);
      chk("t6_rst_freq", 32'(out_freq), 0);
      chk("t6_rst_valid", 32'(out_valid), 0);
      chk("t6_rst_settled", 32'(settled), 1);
      reset = 1'b0;
      wait_upd();
      chk("t6_after_freq", 32'(out_freq), 0);
      chk("t6_after_settled", 32'(settled), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
